// File: rtl/uart485_pkg.sv
// Shared types and helpers for the RS-485 frame transmitter.
// The parity option is selected in the top by the macro UART485_TX_PARITY_EN.
package uart485_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIR_ON  = 3'd1,
    SHIFT   = 3'd2,
    DIR_OFF = 3'd3,
    HOLD    = 3'd4
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;
  localparam logic LINE_STOP  = 1'b1;

  // Wide enough for 9 data bits + parity + start + 2 stops.
  localparam int BIT_IDX_W = 4;

  function automatic logic [BIT_IDX_W-1:0] char_bits(input int data_bits,
                                                      input logic parity_en,
                                                      input logic two_stop);
    char_bits = BIT_IDX_W'(data_bits + 2) + BIT_IDX_W'(parity_en) + BIT_IDX_W'(two_stop);
  endfunction

endpackage

// File: rtl/uart485_frame_tx_baud.sv
// Bit-period counter for the frame transmitter: bit_tick marks the last clock
// of every (div+1)-clock bit; held at zero while clr is high.
module uart485_baud_gen #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [DIV_W-1:0] div,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_r;

  // Up-counter wrapping at the latched divider.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (clr) begin
      cnt_r <= {DIV_W{1'b0}};
    end else if (en) begin
      if (cnt_r == div) begin
        cnt_r <= {DIV_W{1'b0}};
      end else begin
        cnt_r <= cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign bit_tick = en && !clr && (cnt_r == div);

endmodule

// File: rtl/uart485_frame_tx.sv
// RS-485 frame transmitter: direction guard times, N bytes from an addressed
// buffer, 1/2 stop bits. Optional parity bit under macro UART485_TX_PARITY_EN.
module uart485_frame_tx
  import uart485_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int ADDR_W     = 5,
  parameter int DIV_W      = 8,
  parameter int DIR_LEAD   = 10,
  parameter int DIR_LAG    = 5,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rq,
  input  logic [ADDR_W-1:0]    frame_len,
  input  logic [DIV_W-1:0]     clk_div,
  input  logic                 two_stop,
  input  logic [DATA_BITS-1:0] data,
  output logic [ADDR_W-1:0]    addr,
  output logic                 tx,
  output logic                 dir_tx,
  output logic                 dir_rx,
  output logic                 busy,
  output logic                 done
);

`ifdef UART485_TX_PARITY_EN
  localparam int PAR_EN = 1;
`else
  localparam int PAR_EN = 0;
`endif

  localparam int DLY_W = $clog2(2*DIR_LEAD + DIR_LAG + 1);
  localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_BITS);
  localparam logic [BIT_IDX_W-1:0] STOP1_IDX     = BIT_IDX_W'(DATA_BITS + 1 + PAR_EN);
  localparam logic [DLY_W-1:0]     LEAD_LAST     = DLY_W'(DIR_LEAD - 1);
  localparam logic [DLY_W-1:0]     ON_LAST       = DLY_W'(2*DIR_LEAD - 1);
  localparam logic [DLY_W-1:0]     LAG_LAST      = DLY_W'(DIR_LAG - 1);

`ifdef UART485_TX_PARITY_EN
  localparam int PAR_IDX = DATA_BITS + 1;

  function automatic logic parity_of(input logic [DATA_BITS-1:0] d);
    parity_of = (^d) ^ (PARITY_ODD != 0);
  endfunction
`endif

  logic                 rq_meta_r, rqs_r;
  state_t               state_r, state_s;
  logic [DLY_W-1:0]     dly_r, dly_s;
  logic [ADDR_W-1:0]    frame_len_r, frame_len_s;
  logic [DIV_W-1:0]     clk_div_r, clk_div_s;
  logic                 two_stop_r, two_stop_s;
  logic [BIT_IDX_W-1:0] bit_idx_r, bit_idx_s;
  logic [DATA_BITS-1:0] shreg_r, shreg_s;
  logic                 first_r, first_s;
  logic                 last_r, last_s;
  logic [ADDR_W-1:0]    addr_r, addr_s;
  logic                 tx_r, tx_s;
  logic                 dir_tx_r, dir_tx_s;
  logic                 dir_rx_r, dir_rx_s;
  logic                 busy_r, busy_s;
  logic                 done_r, done_s;

  logic                 bit_tick_s;
  logic [DATA_BITS-1:0] cur_data_s;
  logic [BIT_IDX_W-1:0] last_idx_s, nxt_idx_s;
  logic                 data_bit_s;

  // Two-flop synchroniser for the asynchronous request level.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rq_meta_r <= 1'b0;
      rqs_r     <= 1'b0;
    end else begin
      rq_meta_r <= rq;
      rqs_r     <= rq_meta_r;
    end
  end

  uart485_baud_gen #(.DIV_W(DIV_W)) u_baud (
    .clk      (clk),
    .reset    (reset),
    .clr      (state_r != SHIFT),
    .en       (state_r == SHIFT),
    .div      (clk_div_r),
    .bit_tick (bit_tick_s)
  );

  // In the first start-bit clock the byte comes straight from the buffer.
  assign cur_data_s = first_r ? data : shreg_r;
  assign last_idx_s = char_bits(DATA_BITS, PAR_EN != 0, two_stop_r) - BIT_IDX_W'(1);
  assign nxt_idx_s  = bit_idx_r + BIT_IDX_W'(1);
  assign data_bit_s = 1'(cur_data_s >> bit_idx_r);

  // Next-state and next-output logic; all outputs are registered below.
  always_comb begin
    state_s     = state_r;
    dly_s       = dly_r;
    frame_len_s = frame_len_r;
    clk_div_s   = clk_div_r;
    two_stop_s  = two_stop_r;
    bit_idx_s   = bit_idx_r;
    shreg_s     = shreg_r;
    first_s     = 1'b0;
    last_s      = last_r;
    addr_s      = addr_r;
    tx_s        = LINE_IDLE;
    dir_tx_s    = dir_tx_r;
    dir_rx_s    = dir_rx_r;
    busy_s      = busy_r;
    done_s      = 1'b0;

    case (state_r)
      IDLE: begin
        if (rqs_r) begin
          state_s     = DIR_ON;
          frame_len_s = frame_len;
          clk_div_s   = clk_div;
          two_stop_s  = two_stop;
          busy_s      = 1'b1;
          addr_s      = {ADDR_W{1'b0}};
          dly_s       = {DLY_W{1'b0}};
          dir_rx_s    = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end

      DIR_ON: begin
        dly_s = dly_r + DLY_W'(1);
        if (dly_r == LEAD_LAST) begin
          dir_tx_s = 1'b1;
        end else begin
          dir_tx_s = dir_tx_r;
        end
        if (dly_r == ON_LAST) begin
          state_s   = SHIFT;
          bit_idx_s = {BIT_IDX_W{1'b0}};
          first_s   = 1'b1;
          tx_s      = LINE_START;
        end else begin
          state_s = DIR_ON;
        end
      end

      SHIFT: begin
        tx_s    = tx_r;
        shreg_s = cur_data_s;
        if (first_r) begin
          last_s = (addr_r == frame_len_r);
        end else begin
          last_s = last_r;
        end
        if (bit_tick_s) begin
          if (bit_idx_r == last_idx_s) begin
            if (last_s) begin
              state_s  = DIR_OFF;
              dly_s    = {DLY_W{1'b0}};
              addr_s   = {ADDR_W{1'b0}};
              tx_s     = LINE_IDLE;
              dir_tx_s = 1'b0;
            end else begin
              bit_idx_s = {BIT_IDX_W{1'b0}};
              first_s   = 1'b1;
              tx_s      = LINE_START;
            end
          end else begin
            bit_idx_s = nxt_idx_s;
            if (nxt_idx_s <= LAST_DATA_IDX) begin
              tx_s = data_bit_s;
`ifdef UART485_TX_PARITY_EN
            end else if (nxt_idx_s == BIT_IDX_W'(PAR_IDX)) begin
              tx_s = parity_of(cur_data_s);
`endif
            end else begin
              tx_s = LINE_STOP;
            end
            if (nxt_idx_s == STOP1_IDX) begin
              addr_s = addr_r + ADDR_W'(1);
            end else begin
              addr_s = addr_r;
            end
          end
        end else begin
          bit_idx_s = bit_idx_r;
        end
      end

      DIR_OFF: begin
        dly_s = dly_r + DLY_W'(1);
        if (dly_r == LAG_LAST) begin
          state_s  = HOLD;
          dir_rx_s = 1'b0;
          done_s   = 1'b1;
        end else begin
          state_s = DIR_OFF;
        end
      end

      HOLD: begin
        if (!rqs_r) begin
          state_s = IDLE;
          busy_s  = 1'b0;
        end else begin
          state_s = HOLD;
        end
      end

      default: begin
        state_s  = IDLE;
        dir_tx_s = 1'b0;
        dir_rx_s = 1'b0;
        busy_s   = 1'b0;
        addr_s   = {ADDR_W{1'b0}};
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      dly_r       <= {DLY_W{1'b0}};
      frame_len_r <= {ADDR_W{1'b0}};
      clk_div_r   <= {DIV_W{1'b0}};
      two_stop_r  <= 1'b0;
      bit_idx_r   <= {BIT_IDX_W{1'b0}};
      shreg_r     <= {DATA_BITS{1'b0}};
      first_r     <= 1'b0;
      last_r      <= 1'b0;
      addr_r      <= {ADDR_W{1'b0}};
      tx_r        <= LINE_IDLE;
      dir_tx_r    <= 1'b0;
      dir_rx_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      dly_r       <= dly_s;
      frame_len_r <= frame_len_s;
      clk_div_r   <= clk_div_s;
      two_stop_r  <= two_stop_s;
      bit_idx_r   <= bit_idx_s;
      shreg_r     <= shreg_s;
      first_r     <= first_s;
      last_r      <= last_s;
      addr_r      <= addr_s;
      tx_r        <= tx_s;
      dir_tx_r    <= dir_tx_s;
      dir_rx_r    <= dir_rx_s;
      busy_r      <= busy_s;
      done_r      <= done_s;
    end
  end

  assign addr   = addr_r;
  assign tx     = tx_r;
  assign dir_tx = dir_tx_r;
  assign dir_rx = dir_rx_r;
  assign busy   = busy_r;
  assign done   = done_r;

endmodule

// File: tb/tb_uart485_frame_tx.sv
// Randomised bench for uart485_frame_tx against a cycle-indexed frame model.
// Honours UART485_TX_PARITY_EN the same way as the design.
module tb_uart485_frame_tx;

  localparam int DB   = 8;
  localparam int AW   = 5;
  localparam int DW   = 8;
  localparam int LEAD = 10;
  localparam int LAG  = 5;
  localparam int PODD = 0;
`ifdef UART485_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  // Request set just after an edge: 2 sync stages + 1 acceptance clock.
  localparam int ACC = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          rq;
  logic [AW-1:0] frame_len;
  logic [DW-1:0] clk_div;
  logic          two_stop;
  logic [DB-1:0] data;
  logic [AW-1:0] addr;
  logic          tx, dir_tx, dir_rx, busy, done;
  logic [7:0]    mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign data = mem[addr];

  uart485_frame_tx #(
    .DATA_BITS(DB), .ADDR_W(AW), .DIV_W(DW),
    .DIR_LEAD(LEAD), .DIR_LAG(LAG), .PARITY_ODD(PODD)
  ) dut (
    .clk(clk), .reset(reset), .rq(rq), .frame_len(frame_len),
    .clk_div(clk_div), .two_stop(two_stop), .data(data), .addr(addr),
    .tx(tx), .dir_tx(dir_tx), .dir_rx(dir_rx), .busy(busy), .done(done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got {tx,dtx,drx,busy,done,addr}=%h expected %h", tag, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] pack(input logic t, input logic dt, input logic dr,
                                       input logic b, input logic d, input logic [AW-1:0] a);
    return {22'd0, t, dt, dr, b, d, a};
  endfunction

  function automatic logic [31:0] obs();
    return pack(tx, dir_tx, dir_rx, busy, done, addr);
  endfunction

  // Expected outputs k clocks after rq is raised, from the frame rules.
  function automatic logic [31:0] expect_at(input int k, input int fl, input int dv, input int ts);
    int nb   = 2 + DB + PAR + ts;
    int per  = dv + 1;
    int len  = (fl + 1) * nb * per;
    int t_tx = ACC + LEAD;
    int s0   = t_tx + LEAD;
    int bitpos, ch, b;
    logic [7:0] d;
    logic t = 1'b1;
    logic [AW-1:0] a = '0;
    if (k >= s0 && k < s0 + len) begin
      bitpos = (k - s0) / per;
      ch     = bitpos / nb;
      b      = bitpos % nb;
      d      = mem[ch];
      if (b == 0)                  t = 1'b0;
      else if (b <= DB)            t = d[b-1];
      else if (PAR == 1 && b == DB + 1) t = (^d) ^ (PODD != 0);
      else                         t = 1'b1;
      a = AW'(ch + ((b >= DB + 1 + PAR) ? 1 : 0));
    end
    return pack(t, (k >= t_tx && k < s0 + len), (k >= ACC && k < s0 + len + LAG),
                (k >= ACC), (k == s0 + len + LAG), a);
  endfunction

  // Raise rq and check every clock; abort_k > 0 stops checking early.
  task automatic run_frame(input int fl, input int dv, input int ts, input bit scramble,
                           input int abort_k, input string tag);
    int len, kend;
    @(negedge clk);
    frame_len = AW'(fl);
    clk_div   = DW'(dv);
    two_stop  = ts[0];
    rq        = 1'b1;
    len  = (fl + 1) * (2 + DB + PAR + ts) * (dv + 1);
    kend = (abort_k > 0) ? abort_k : ACC + 2*LEAD + len + LAG + 4;
    for (int k = 1; k <= kend; k++) begin
      @(negedge clk);
      check_eq(tag, obs(), expect_at(k, fl, dv, ts));
      if (scramble && k == 30) begin
        frame_len = AW'($urandom);
        clk_div   = DW'($urandom_range(0, 7));
        two_stop  = ~two_stop;
      end
    end
  endtask

  task automatic drop_rq(input string tag);
    @(negedge clk);
    rq = 1'b0;
    @(negedge clk);
    check_eq({tag, "_hold1"}, obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    @(negedge clk);
    check_eq({tag, "_hold2"}, obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    @(negedge clk);
    check_eq({tag, "_idle"}, obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    reset     = 1'b0;
    rq        = 1'b0;
    frame_len = '0;
    clk_div   = '0;
    two_stop  = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = 8'hA0 + 8'(i);

    repeat (3) @(negedge clk);
    check_eq("reset_state", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("idle_state", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));

    // Four bytes A0..A3 at one clock per bit, then a long held request.
    run_frame(3, 0, 0, 1'b0, 0, "frame4");
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      check_eq("no_retrigger", obs(), pack(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, '0));
    end
    drop_rq("frame4");
    run_frame(3, 0, 0, 1'b0, 0, "frame4_again");
    drop_rq("frame4_again");

    // Single 0x55 byte, 5 clocks per bit, two stop bits.
    mem[0] = 8'h55;
    run_frame(0, 4, 1, 1'b0, 0, "slow_2stop");
    drop_rq("slow_2stop");

    // Parity-relevant patterns (odd and even population).
    mem[0] = 8'h07;
    run_frame(0, 0, 0, 1'b0, 0, "pat07");
    drop_rq("pat07");
    mem[0] = 8'h03;
    run_frame(0, 1, 0, 1'b0, 0, "pat03");
    drop_rq("pat03");

    // Inputs change mid-frame; latched values must govern.
    fill_random();
    run_frame(2, 1, 0, 1'b1, 0, "midchange");
    drop_rq("midchange");

    // Asynchronous reset in the middle of byte 2.
    fill_random();
    run_frame(3, 1, 0, 1'b0, ACC + 2*LEAD + 2*(2 + DB + PAR)*2 + 5, "pre_reset");
    #2 reset = 1'b0;
    #1 check_eq("async_reset", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    rq = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("after_reset", obs(), pack(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, '0));
    run_frame(3, 1, 0, 1'b0, 0, "post_reset");
    drop_rq("post_reset");

    // Random frames.
    for (int n = 0; n < 8; n++) begin
      fill_random();
      run_frame($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 1),
                1'b0, 0, "random");
      drop_rq("random");
    end

    // Longest frame: 32 bytes, address wraps back to 0 at the end.
    fill_random();
    run_frame(31, 0, 0, 1'b0, 0, "max_len");
    drop_rq("max_len");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart485_frame_tx.md
Name: uart485_frame_tx

Overview:
- Parametrised RS-485 frame transmitter. Successor of the fixed 8N1, fixed-length TX block.
- On a request it asserts the transceiver direction pins with guard delays, then serialises a run-time-selected number of bytes fetched by address from an external buffer, then releases the bus.
- Adds over the previous generation: configurable data width, runtime frame length, runtime baud divider, 1/2 stop bits, busy/done status.
- Sits between the frame buffer (RAM/mux driven by addr) and the RS-485 transceiver pins.

Parameters:
- DATA_BITS, 8, data bits per character (5..9), LSB first.
- ADDR_W, 5, width of addr and frame_len.
- DIV_W, 8, width of baud divider.
- DIR_LEAD, 10, clocks from dir_rx high to dir_tx high; first start bit begins DIR_LEAD clocks after dir_tx.
- DIR_LAG, 5, clocks from dir_tx low to dir_rx low.
- PARITY_ODD, 0, parity sense when parity is compiled in (0 even, 1 odd).

Ports:
- clk  in  1  bit clock
- reset  in  1  reset, asynchronous, active-low
- rq  in  1  transfer request, asynchronous to clk, level
- frame_len  in  ADDR_W  bytes to send minus 1; sampled on request acceptance
- clk_div  in  DIV_W  clocks per bit minus 1; sampled on request acceptance
- two_stop  in  1  1 = two stop bits; sampled on request acceptance
- data  in  DATA_BITS  byte at addr; sampled at each start-bit cycle
- addr  out  ADDR_W  buffer index of the current byte
- tx  out  1  serial line, idle high
- dir_tx  out  1  RS-485 driver enable
- dir_rx  out  1  RS-485 receiver-disable/dir control
- busy  out  1  high from request acceptance until return to IDLE
- done  out  1  one-clock pulse on entry to HOLD

Behaviour:
- Reset values (immediate and asynchronous, also mid-frame): tx=1, dir_tx=0, dir_rx=0, addr=0, busy=0, done=0, state=IDLE, all counters 0.
- rq passes a 2-FF synchroniser. rqs is the second stage.
- IDLE:
  - rqs=1 → DIR_ON.
  - Latch frame_len, clk_div, two_stop.
  - Set busy=1, addr=0, dly=0.
- DIR_ON: dly increments each clock.
  - dly==0: dir_rx←1.
  - dly==DIR_LEAD: dir_tx←1.
  - dly==2*DIR_LEAD: → SHIFT, bit index 0, baud counter 0.
- SHIFT: each bit lasts clk_div+1 clocks, counted by the baud counter, which wraps at the latched clk_div.
  - Character sequence: start(0), data[0..DATA_BITS-1], [parity], stop(1), [second stop if two_stop].
  - data is captured into the shift register in the first clock of the start bit.
  - addr increments in the first clock of the (first) stop bit.
  - After the last stop bit of byte index frame_len → DIR_OFF, dly=0, addr=0.
  - Otherwise the next start bit follows immediately with no idle gap.
- DIR_OFF: dly increments.
  - dly==0: dir_tx←0.
  - dly==DIR_LAG: dir_rx←0, → HOLD, done=1 for one clock.
- HOLD: waits for rqs=0, then → IDLE with busy=0. A request held high never retriggers.
- frame_len=0 sends exactly 1 byte. Maximum is 2^ADDR_W bytes; addr wraps only through the end-of-frame reset.
- clk_div=0 gives 1 clock per bit.
- rq toggling during DIR_ON/SHIFT/DIR_OFF is ignored.
- Changes to frame_len/clk_div/two_stop mid-frame have no effect.
- tx stays 1 whenever state ≠ SHIFT.

Optional Feature:
- Macro UART485_TX_PARITY_EN.
- Defined: a parity bit follows the data bits.
  - Value = XOR of the captured data, inverted when PARITY_ODD=1.
  - Character length = DATA_BITS+3 (+1 if two_stop) bits.
- Undefined: no parity bit, no parity logic; the PARITY_ODD parameter is unused.

Decomposition:
- Package uart485_pkg holds:
  - state enum (IDLE, DIR_ON, SHIFT, DIR_OFF, HOLD);
  - localparams for idle/start/stop line levels;
  - a function computing character bit count from DATA_BITS, parity enable and two_stop.
- One natural sub-module, uart485_baud_gen: loadable down/up counter producing a one-clock bit_tick every clk_div+1 clocks. It is reset by the FSM at frame start.

Test Plan:
- Defaults, frame_len=3, clk_div=0, data=addr+8'hA0, rq held high → ordering and timing:
  - dir_rx rises 3 clocks after rq;
  - dir_tx rises 10 clocks later;
  - start bit 10 clocks after dir_tx;
  - 4 bytes A0..A3 LSB-first 8N1;
  - dir_tx falls after the last stop bit, dir_rx 5 clocks later;
  - done pulses once;
  - busy stays high until rq drops.
- clk_div=4, two_stop=1, frame_len=0, data=8'h55 → every bit 5 clocks wide; one character of 55 clocks (11 bits); addr 0→1→0.
- Rq kept high 1000 clocks after done → no second frame. Drop and reassert rq → second identical frame.
- Async reset asserted mid-byte 2 → tx=1, dir_tx=dir_rx=0, addr=0, busy=0 immediately. The next request sends a full frame from addr 0.
- UART485_TX_PARITY_EN with PARITY_ODD=0, data=8'h07 → parity bit 1. With data=8'h03 → parity bit 0. Without the macro, the stop bit directly follows data[7].
- Change clk_div and frame_len during SHIFT → the frame completes with the originally latched values.
